// File: rtl/core_ctx_state_ctrl.sv
// Multi-context run-state controller. Each hardware context has an IDLE/RUN/HALT/ERR state,
// a captured exception code and a watchdog. Contexts are driven by retires and network commands.
module core_ctx_state_ctrl #(
  parameter int unsigned NUM_CTX    = 4,
  parameter int unsigned EXC_CODE_W = 4,
  parameter int unsigned WDOG_W     = 16,
  localparam int unsigned CTX_W     = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1
) (
  input  logic                           clk,
  input  logic                           n_reset,
  input  logic                           instr_valid_i,
  input  logic [CTX_W-1:0]               ctx_i,
  input  logic                           instr_done_i,
  input  logic                           exception_i,
  input  logic [EXC_CODE_W-1:0]          exc_code_i,
  input  logic                           stall_i,
  input  logic                           net_start_i,
  input  logic                           net_halt_i,
  input  logic                           net_resume_i,
  input  logic                           net_clear_i,
  input  logic [CTX_W-1:0]               net_ctx_i,
  input  logic [WDOG_W-1:0]              wdog_limit_i,
  output logic [2*NUM_CTX-1:0]           state_o,
  output logic [NUM_CTX-1:0]             run_mask_o,
  output logic [EXC_CODE_W*NUM_CTX-1:0]  err_code_o,
  output logic                           any_err_o,
  output logic                           all_idle_o,
  output logic                           cmd_err_o
);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StHalt = 2'b10,
    StErr  = 2'b11
  } ctx_state_e;

  ctx_state_e              state_q [NUM_CTX];
  ctx_state_e              state_d [NUM_CTX];
  logic [EXC_CODE_W-1:0]   err_q   [NUM_CTX];
  logic [EXC_CODE_W-1:0]   err_d   [NUM_CTX];
  logic [WDOG_W-1:0]       wdog_q  [NUM_CTX];
  logic [WDOG_W-1:0]       wdog_d  [NUM_CTX];
  logic                    cmd_err_q, cmd_err_d;

  logic [NUM_CTX-1:0]      retire, wdog_trip, cmd_hit;
  logic [2:0]              cmd_cnt;
  logic                    cmd_any, net_ctx_ok, cmd_valid;

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      for (int unsigned c = 0; c < NUM_CTX; c++) begin
        state_q[c] <= StIdle;
        err_q[c]   <= '0;
        wdog_q[c]  <= '0;
      end
      cmd_err_q <= 1'b0;
    end else begin
      for (int unsigned c = 0; c < NUM_CTX; c++) begin
        state_q[c] <= state_d[c];
        err_q[c]   <= err_d[c];
        wdog_q[c]  <= wdog_d[c];
      end
      cmd_err_q <= cmd_err_d;
    end
  end

  // Command decode: exactly one command bit and an in-range target make a valid command.
  always_comb begin
    cmd_cnt    = {2'b00, net_start_i} + {2'b00, net_halt_i} + {2'b00, net_resume_i}
               + {2'b00, net_clear_i};
    cmd_any    = (cmd_cnt != 3'd0);
    net_ctx_ok = ({{(32-CTX_W){1'b0}}, net_ctx_i} < NUM_CTX);
    cmd_valid  = (cmd_cnt == 3'd1) && net_ctx_ok;
    cmd_err_d  = (cmd_cnt > 3'd1) || (cmd_any && !net_ctx_ok);
    for (int unsigned c = 0; c < NUM_CTX; c++) begin
      retire[c]    = instr_valid_i && !stall_i && (ctx_i == CTX_W'(c));
      wdog_trip[c] = (state_q[c] == StRun) && (wdog_limit_i != '0)
                     && (wdog_q[c] >= wdog_limit_i);
      cmd_hit[c]   = cmd_valid && (net_ctx_i == CTX_W'(c));
    end
  end

  always_comb begin
    for (int unsigned c = 0; c < NUM_CTX; c++) begin
      state_d[c] = state_q[c];
      err_d[c]   = err_q[c];
      if (retire[c] && exception_i && (state_q[c] == StRun || state_q[c] == StHalt)) begin
        state_d[c] = StErr;
        err_d[c]   = exc_code_i;
      end else if (wdog_trip[c]) begin
        state_d[c] = StErr;
        err_d[c]   = '1;
      end else if (retire[c] && instr_done_i && (state_q[c] == StRun)) begin
        state_d[c] = StIdle;
      end else if (cmd_hit[c]) begin
        unique case (state_q[c])
          StIdle: if (net_start_i)  state_d[c] = StRun;
          StRun:  if (net_halt_i)   state_d[c] = StHalt;
          StHalt: if (net_resume_i) state_d[c] = StRun;
          StErr: begin
            if (net_clear_i) begin
              state_d[c] = StIdle;
              err_d[c]   = '0;
            end
          end
          default: ;
        endcase
      end

      // Watchdog counts only while running; a resume from HALT keeps the frozen count.
      if (state_d[c] == StIdle || state_d[c] == StErr) begin
        wdog_d[c] = '0;
      end else if (state_q[c] == StRun) begin
        if (retire[c])             wdog_d[c] = '0;
        else if (&wdog_q[c])       wdog_d[c] = wdog_q[c];
        else                       wdog_d[c] = wdog_q[c] + 1'b1;
      end else if (state_q[c] == StHalt) begin
        wdog_d[c] = wdog_q[c];
      end else begin
        wdog_d[c] = '0;
      end
    end
  end

  always_comb begin
    state_o    = '0;
    run_mask_o = '0;
    err_code_o = '0;
    any_err_o  = 1'b0;
    all_idle_o = 1'b1;
    for (int unsigned c = 0; c < NUM_CTX; c++) begin
      state_o[2*c +: 2]                   = state_q[c];
      run_mask_o[c]                       = (state_q[c] == StRun);
      err_code_o[EXC_CODE_W*c +: EXC_CODE_W] = err_q[c];
      any_err_o                           = any_err_o | (state_q[c] == StErr);
      all_idle_o                          = all_idle_o & (state_q[c] == StIdle);
    end
    cmd_err_o = cmd_err_q;
  end

endmodule
